// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 registers the operation, S2 registers the
// result and flags. Also tracks a sticky overflow flag and a wrapping event count.
module alu_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  input  logic             clr_sticky,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_EQ  = 3'b111
  } op_e;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;

  logic             accept;
  logic             s2_load;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;

  // S1 may advance into a free S2 or into one being drained this cycle.
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    sum_ext = '0;
    res_c   = '0;
    ovf_c   = 1'b0;
    unique case (s1_op)
      OP_ADD: begin
        sum_ext = {s1_a[WIDTH-1], s1_a} + {s1_b[WIDTH-1], s1_b};
        ovf_c   = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
        res_c   = sum_ext[WIDTH-1:0];
      end
      OP_SUB: begin
        sum_ext = {s1_a[WIDTH-1], s1_a} - {s1_b[WIDTH-1], s1_b};
        ovf_c   = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
        res_c   = sum_ext[WIDTH-1:0];
      end
      OP_NOT: res_c = ~s1_a;
      OP_AND: res_c = s1_a & s1_b;
      OP_OR:  res_c = s1_a | s1_b;
      OP_XOR: res_c = s1_a ^ s1_b;
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      OP_EQ:  res_c = {{(WIDTH-1){1'b0}}, (s1_a == s1_b)};
    endcase
    // An overflowed sum is reported as zero rather than a wrapped value.
    if (ovf_c) res_c = '0;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= op_e'(op);
      s1_a     <= a;
      s1_b     <= b;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: the visible result and flags are reset too, so outputs read 0/zero=1 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      result   <= res_c;
      overflow <= ovf_c;
      zero     <= (res_c == '0);
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // A new overflow event takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (s2_load && ovf_c) begin
      ovf_sticky <= 1'b1;
      ovf_count  <= clr_sticky ? CNT_W'(1) : ovf_count + CNT_W'(1);
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, stall/reset/counter
// sequences, and a randomized stream scored against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 4;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         overflow;
  logic         zero;
  logic         clr_sticky = 1'b0;
  logic         ovf_sticky;
  logic [C-1:0] ovf_count;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  alu_pipe #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .zero(zero),
    .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         zero;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
    logic         zero;
  } vec_t;

  exp_t q[$];
  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signed integer arithmetic with an explicit representable-range test.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int sx;
    int sy;
    int s;
    int max_s;
    int min_s;
    e     = '0;
    sx    = $signed(x);
    sy    = $signed(y);
    max_s = (1 << (W - 1)) - 1;
    min_s = -(1 << (W - 1));
    s     = 0;
    case (o)
      3'd0, 3'd1: begin
        s = (o == 3'd0) ? sx + sy : sx - sy;
        if (s > max_s || s < min_s) e.ovf = 1'b1;
        else e.res = W'(s);
      end
      3'd2: e.res = ~x;
      3'd3: e.res = x & y;
      3'd4: e.res = x | y;
      3'd5: e.res = x ^ y;
      3'd6: e.res = (sx < sy) ? W'(1) : W'(0);
      default: e.res = (x == y) ? W'(1) : W'(0);
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Scoreboard: handshakes are judged on the falling edge, where all signals are settled.
  initial begin : monitor
    logic         stall_prev;
    logic [W-1:0] res_prev;
    logic         ovf_prev;
    logic         zero_prev;
    exp_t         e;
    stall_prev = 1'b0;
    res_prev   = '0;
    ovf_prev   = 1'b0;
    zero_prev  = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        stall_prev = 1'b0;
      end else if (!clk) begin
        if (stall_prev) begin
          check("hold_valid", out_valid, 1);
          check("hold_result", result, res_prev);
          check("hold_overflow", overflow, ovf_prev);
          check("hold_zero", zero, zero_prev);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("spurious_output", out_valid, 0);
          end else begin
            e = q.pop_front();
            check("sb_result", result, e.res);
            check("sb_overflow", overflow, e.ovf);
            check("sb_zero", zero, e.zero);
            n_out++;
          end
        end
        if (in_valid && in_ready) q.push_back(model(op, a, b));
        stall_prev = out_valid && !out_ready;
        res_prev   = result;
        ovf_prev   = overflow;
        zero_prev  = zero;
      end
    end
  end

  // Caller positions just after a rising edge; returns at the falling edge after N+1.
  task automatic apply_vec(input int i);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    op        = vecs[i].op;
    a         = vecs[i].a;
    b         = vecs[i].b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("vec%0d_valid", i), out_valid, 1);
    check($sformatf("vec%0d_result", i), result, vecs[i].res);
    check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
    check($sformatf("vec%0d_zero", i), zero, vecs[i].zero);
  endtask

  task automatic send_n(input int n, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int acc;
    acc = 0;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    op = o; a = x; b = y;
    for (int c = 0; c < 2 * n + 10 && acc < n; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
      if (acc >= n) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("send_n_accepts", acc, n);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int           base;
    int           acc;
    int           stale;
    logic         saw_block;

    vecs[0]  = '{3'd0, 4'h7, 4'h1, 4'h0, 1'b1, 1'b1};
    vecs[1]  = '{3'd0, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0};
    vecs[2]  = '{3'd1, 4'h8, 4'h1, 4'h0, 1'b1, 1'b1};
    vecs[3]  = '{3'd1, 4'h2, 4'h5, 4'hD, 1'b0, 1'b0};
    vecs[4]  = '{3'd6, 4'hF, 4'h0, 4'h1, 1'b0, 1'b0};
    vecs[5]  = '{3'd6, 4'h0, 4'hF, 4'h0, 1'b0, 1'b1};
    vecs[6]  = '{3'd7, 4'h5, 4'h5, 4'h1, 1'b0, 1'b0};
    vecs[7]  = '{3'd2, 4'h5, 4'h0, 4'hA, 1'b0, 1'b0};
    vecs[8]  = '{3'd3, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0};
    vecs[9]  = '{3'd4, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0};
    vecs[10] = '{3'd5, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0};
    vecs[11] = '{3'd7, 4'h5, 4'h4, 4'h0, 1'b0, 1'b1};
    vecs[12] = '{3'd0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1};
    vecs[13] = '{3'd0, 4'h7, 4'hF, 4'h6, 1'b0, 1'b0};
    vecs[14] = '{3'd1, 4'h7, 4'h8, 4'h0, 1'b1, 1'b1};

    // Asynchronous reset: outputs settle with no clock edge in between.
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    check("rst_zero", zero, 1);
    check("rst_sticky", ovf_sticky, 0);
    check("rst_count", ovf_count, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // First op is offered so it is taken on the first rising edge out of reset.
    apply_vec(0);
    check("first_ovf_sticky", ovf_sticky, 1);
    check("first_ovf_count", ovf_count, 1);
    for (int i = 1; i < 15; i++) begin
      @(posedge clk);
      #1;
      apply_vec(i);
    end
    check("table_ovf_count", ovf_count, 4);

    // Six back-to-back ops with the sink stalled for cycles 2..5.
    base      = n_out;
    acc       = 0;
    saw_block = 1'b0;
    op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      #1;
      in_valid  = (acc < 6);
      out_ready = !(c >= 2 && c <= 5);
      @(negedge clk);
      if (c == 2) check("stall_in_ready_low", in_ready, 0);
      if (!in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) begin
        acc++;
        @(posedge clk);
        #1;
        op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
        in_valid  = (acc < 6);
        out_ready = !(c + 1 >= 2 && c + 1 <= 5);
        c++;
        @(negedge clk);
        if (!in_ready) saw_block = 1'b1;
        if (in_valid && in_ready) acc++;
        if (in_valid && in_ready) begin
          @(posedge clk);
          #1;
          op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
          in_valid = (acc < 6);
          c++;
          out_ready = !(c >= 2 && c <= 5);
          @(negedge clk);
          if (!in_ready) saw_block = 1'b1;
          if (in_valid && in_ready) acc++;
        end
      end
    end
    in_valid = 1'b0;
    check("stall_saw_block", saw_block, 1);
    check("stall_accepts", acc, 6);
    check("stall_outputs", n_out - base, 6);

    // Random traffic, inputs change every cycle whether or not accepted.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("random_drained", q.size(), 0);

    // Clear, then 256 overflow events wrap the 8-bit counter.
    clr_sticky = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
    check("clr_sticky", ovf_sticky, 0);
    check("clr_count", ovf_count, 0);
    send_n(256, 3'd0, 4'h7, 4'h1);
    check("wrap_count", ovf_count, 0);
    check("wrap_sticky", ovf_sticky, 1);
    send_n(2, 3'd1, 4'h8, 4'h1);
    check("post_wrap_count", ovf_count, 2);

    // Clear coinciding with an overflowed S2 load: the new event wins.
    in_valid = 1'b1; out_ready = 1'b1;
    op = 3'd0; a = 4'h7; b = 4'h1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    clr_sticky = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
    check("clr_vs_event_count", ovf_count, 1);
    check("clr_vs_event_sticky", ovf_sticky, 1);
    repeat (3) @(posedge clk);
    #1;

    // Fill both stages against a stalled sink, then reset mid-flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op = 3'd0; a = 4'h3; b = 4'h4;
    @(posedge clk);
    #1 a = 4'h1; b = 4'h1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    check("full_result", result, 7);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 1);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_output", stale, 0);
    @(posedge clk);
    #1;
    apply_vec(3);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2 to 64).
- REQ-002: The block SHALL have parameter CNT_W, default 8, giving the width of the overflow event counter.
- REQ-003: Ports, in order:
  - clk  input  1  sole clock; all state changes on its rising edge.
  - rst_n  input  1  asynchronous, active-low reset.
- REQ-004: `in_valid  input  1` -- the upstream operation is valid.
- REQ-005: `in_ready  output  1` -- the block can accept an operation this cycle.
- REQ-006: `op  input  3` -- opcode, per REQ-013.
- REQ-007: Operand ports:
  - a  input  WIDTH  operand A, two's complement.
  - b  input  WIDTH  operand B, two's complement.
- REQ-008: `out_valid  output  1` -- result, overflow and zero are valid.
- REQ-009: `out_ready  input  1` -- downstream accepts the result.
- REQ-010: Result ports:
  - result  output  WIDTH  operation result.
  - overflow  output  1  signed overflow on ADD/SUB.
  - zero  output  1  high when result is all zeros.
- REQ-011: Status ports:
  - clr_sticky  input  1  synchronous clear for ovf_sticky and ovf_count.
  - ovf_sticky  output  1  high once any overflowed result has entered stage 2.
  - ovf_count  output  CNT_W  number of overflowed results entering stage 2; wraps modulo 2^CNT_W.

Function
- REQ-012: Pipeline structure:
  - Two register stages.
  - S1 captures op, a and b when in_valid && in_ready.
  - S2 captures the computed result and flags from S1.
- REQ-013: Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 NOT: ~a.
  - 011 AND: a&b.
  - 100 OR: a|b.
  - 101 XOR: a^b.
  - 110 SLT: 1 if a<b signed, else 0.
  - 111 EQ: 1 if a==b, else 0.
- REQ-014: ADD and SUB SHALL be computed on WIDTH+1 sign-extended operands. overflow=1 exactly when bits WIDTH and WIDTH-1 of that sum differ. When overflow=1, result SHALL be forced to 0.
- REQ-015: overflow SHALL be 0 for every opcode other than ADD and SUB.
- REQ-016: SLT and EQ SHALL zero-extend their 1-bit outcome to WIDTH bits.
- REQ-017: zero SHALL be high exactly when the final result (after any force-to-0) is all zeros. A forced overflow result therefore also raises zero.
- REQ-018: in_ready SHALL equal !s1_valid || !s2_valid || out_ready; it is combinational, with no dependence on in_valid.
- REQ-019: S2 SHALL load whenever s1_valid && (!s2_valid || out_ready).
- REQ-020: s1_valid SHALL clear when S1 advances and no new operation is accepted in the same cycle.
- REQ-021: out_valid SHALL equal s2_valid.
- REQ-022: s2_valid SHALL clear on out_valid && out_ready unless S2 reloads in the same cycle.
- REQ-023: While out_valid && !out_ready, result, overflow and zero SHALL be held stable.
- REQ-024: Latency: an operation accepted at rising edge N SHALL present out_valid=1 after edge N+1, provided S2 is free.
- REQ-025: Throughput: one operation per cycle when out_ready is held high.
- REQ-026: No operation SHALL be dropped, duplicated or reordered under any in_valid/out_ready pattern.
- REQ-027: Each load of S2 with overflow=1 SHALL set ovf_sticky and increment ovf_count by 1, wrapping from all-ones to 0.
- REQ-028: clr_sticky=1 SHALL clear ovf_sticky and ovf_count at the next edge.
- REQ-029: If clr_sticky coincides with an overflowed S2 load, the result SHALL be ovf_sticky=1 and ovf_count=1 (the new event wins).
- REQ-030: Input values on op, a and b while no transfer occurs SHALL have no effect.

Reset
- REQ-031: rst_n=0 SHALL immediately, without waiting for a clock edge, force:
  - s1_valid=0 and out_valid=0;
  - result=0, overflow=0, zero=1;
  - ovf_sticky=0, ovf_count=0.
  - in_ready SHALL then read 1.
- REQ-032: Reset asserted mid-operation SHALL discard all in-flight operations; nothing in flight SHALL emerge after release.
- REQ-033: The first accept SHALL be possible on the first rising edge with rst_n=1.

Verification (WIDTH=4, CNT_W=8)
- REQ-034: ADD a=7, b=1 -> result=0, overflow=1, zero=1, ovf_sticky=1, ovf_count=1. Then ADD 3+4 -> result=7, overflow=0, zero=0.
- REQ-035: SUB a=-8 (1000), b=1 -> result=0, overflow=1. SUB 2-5 -> result=1101, overflow=0.
- REQ-036: SLT a=-1, b=0 -> result=0001. SLT 0,-1 -> 0000. EQ 5,5 -> 0001. NOT 0101 -> 1010.
- REQ-037: Back-to-back stream of 6 ops with out_ready held low for cycles 2-5:
  - in_ready falls to 0 once S1 and S2 are both full;
  - out_valid and result are held stable while stalled;
  - all 6 results emerge in order with no loss.
- REQ-038: Wrap and clear: 256 overflowing ADDs -> ovf_count wraps to 0 with ovf_sticky=1. clr_sticky pulsed together with an overflowing S2 load -> ovf_count=1.
- REQ-039: rst_n pulsed low while S1 and S2 are both valid -> out_valid=0 and result=0 immediately, and no stale result appears after release.
